pwm_multi_ch: RTL
=================

# pwm_multi_ch

Parametrised multi-channel PWM generator for the motor drive path. It replaces the single fixed 4-bit PWM and its external clock dividers with an internal prescaler, a programmable period, and per-channel duty and direction. Each channel has a shadow register that updates glitch-free at period boundaries, and a dead-time interlock on direction reversal. It sits between the command/sequencer logic (writes) and the motor driver pins (spd/dir).

## Interface
- CHANNELS, 4: number of PWM channels (1..16)
- WIDTH, 8: width of period counter and duty values
- PRESC_W, 16: prescaler width
- DEADTIME, 2: PWM periods of forced-low spd on a direction change (0 = none)
- RAMP_STEP, 4: max duty change per period (used only with PWM_RAMP_EN)

- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- prescale  in  PRESC_W  tick every prescale+1 clk cycles
- period  in  WIDTH  counter runs 0..period, i.e. period+1 ticks per PWM period
- wr_en  in  1  write strobe, always accepted
- wr_ch  in  max(1,$clog2(CHANNELS))  target channel; values >= CHANNELS ignored
- wr_duty  in  WIDTH  duty in ticks
- wr_dir  in  1  direction
- spd  out  CHANNELS  PWM outputs, registered
- dir  out  CHANNELS  direction outputs, registered
- period_start  out  1  one-clk pulse on each period wrap

## Operation
- Reset: prescaler count, period count, all shadow/active duty, dir and dead counters = 0; all channels in RUN; spd = 0, dir = 0, period_start = 0.
- Prescaler: pcnt increments each clk; when pcnt >= prescale, tick = 1 and pcnt <= 0. prescale = 0 gives a tick every clk. A live prescale decrease below pcnt ticks on the next clk.
- Period counter: advances only on tick; on tick with cnt >= period, wrap: cnt <= 0. Otherwise cnt <= cnt+1. period = 0 wraps every tick.
- Write: on wr_en, shadow_duty[wr_ch] <= wr_duty and shadow_dir[wr_ch] <= wr_dir. Multiple writes within one period: last wins.
- On wrap, per channel:
  - RUN, shadow_dir == active_dir: active_duty <= shadow_duty.
  - RUN, dir differs and DEADTIME > 0: go to DEAD, dead_cnt <= DEADTIME-1, active_duty <= 0. The dir output keeps its old value.
  - RUN, dir differs and DEADTIME == 0: load duty and dir immediately.
  - DEAD, dead_cnt != 0: dead_cnt <= dead_cnt-1.
  - DEAD, dead_cnt == 0: go to RUN; load shadow duty and dir.
- spd[i] <= RUN && (cnt < active_duty[i]). duty 0 gives constant low. duty > period gives constant high. In DEAD, spd is low.
- A write in the same cycle as a wrap is not seen by that wrap; the active value loads the pre-edge shadow, and the new value applies at the next wrap.
- A shadow dir change that reverts before the wrap causes no dead time.

## Timing
- Write at edge k: the shadow updates at edge k. Duty takes effect at the first wrap after k. spd shows it one clk after that wrap.
- spd, dir and period_start are registered. Each lags its cnt/state decision by exactly 1 clk.
- period_start is high for the one clk following each wrap edge.
- PWM period = (prescale+1)·(period+1) clk cycles. Duty resolution = 1 tick.
- Direction reversal: spd is low for exactly DEADTIME full periods. The new dir and spd appear together at the start of the next period.
- rst asserted mid-period clears all state at once. The first wrap after release occurs (prescale+1)·(period+1) clks later.

## Configuration
- PWM_RAMP_EN defined: at each wrap in RUN, active_duty moves toward shadow_duty by at most RAMP_STEP (saturating, no overshoot). Exiting DEAD starts from 0 and ramps up.
- PWM_RAMP_EN undefined: active_duty loads shadow_duty directly. RAMP_STEP is unused.

## Test plan
- Reset then prescale=0, period=9, write ch0 duty=3 dir=0 → after the first wrap, spd[0] is high for 3 of every 10 clks; period_start pulses every 10 clks.
- prescale=3, period=4, ch1 duty=5 → spd[1] is constantly high; the period is 20 clks. ch1 duty=0 → spd[1] is constantly low from the next wrap.
- ch2 running duty=4 dir=0, then write dir=1 duty=6 with DEADTIME=2 → spd[2] is low for 2 full periods with dir[2]=0, then dir[2]=1 and duty 6.
- Write ch3 duty=7 in the exact cycle of a wrap → the old duty runs for one more period, then 7.
- With PWM_RAMP_EN, RAMP_STEP=4: ch0 duty goes 0→10 → active duty is 4, 8, 10 on successive periods.
- Assert rst mid-pulse with spd high → spd/dir/period_start go to 0 immediately (asynchronously). Writes are ignored while rst is high. Writes with wr_ch >= CHANNELS change nothing.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch
//   Multi-channel PWM generator for the motor drive path. One prescaler
//   divides clk into ticks. One period counter is shared by all channels and
//   runs 0..period on ticks. Each channel has a shadow duty/direction that the
//   write port updates at any time. The shadow is copied into the active
//   registers only at a period wrap, so the outputs never glitch mid-period.
//   A direction reversal holds spd low for DEADTIME whole periods. After that
//   the new direction and duty appear together.
//
//   Build option: define PWM_RAMP_EN to slew the active duty toward the
//   shadow by at most RAMP_STEP per period. When PWM_RAMP_EN is not defined,
//   the shadow duty loads directly.
//
// Parameters
//   CHANNELS   number of PWM channels (1..16)
//   WIDTH      width of period counter and duty values
//   PRESC_W    prescaler width
//   DEADTIME   whole PWM periods of forced-low spd on a direction change
//   RAMP_STEP  max duty change per period (PWM_RAMP_EN builds only)
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-high
//   prescale      tick every prescale+1 clk cycles
//   period        counter runs 0..period (period+1 ticks per PWM period)
//   wr_en         write strobe, always accepted
//   wr_ch         target channel; values >= CHANNELS are ignored
//   wr_duty       duty in ticks
//   wr_dir        direction
//   spd           PWM outputs, registered
//   dir           direction outputs, registered
//   period_start  one-clk pulse following each period wrap

module pwm_multi_ch #(
  parameter int  CHANNELS  = 4,
  parameter int  WIDTH     = 8,
  parameter int  PRESC_W   = 16,
  parameter int  DEADTIME  = 2,
  parameter int  RAMP_STEP = 4,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic [WIDTH-1:0]    period,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  input  logic                wr_dir,
  output logic [CHANNELS-1:0] spd,
  output logic [CHANNELS-1:0] dir,
  output logic                period_start
);

  // The dead counter holds DEADTIME-1 down to 0, so it needs clog2(DEADTIME)
  // bits. One bit is kept as a floor so that DEADTIME of 0 or 1 still builds.
  localparam int              DC_W      = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DC_W-1:0] DEAD_INIT = (DEADTIME > 0) ? DC_W'(DEADTIME - 1) : '0;

  // The ramp increment is clamped to the duty range. A step as large as the
  // whole range always lands exactly on the target.
  localparam int             STEP_SAT = (RAMP_STEP > (2 ** WIDTH)) ? (2 ** WIDTH) : RAMP_STEP;
  localparam logic [WIDTH:0] RAMP_INC = (WIDTH + 1)'(STEP_SAT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } ch_state_t;

  logic [PRESC_W-1:0] pcnt;
  logic [WIDTH-1:0]   cnt;
  logic               tick;
  logic               wrap;

  logic [WIDTH-1:0]    shadow_duty [CHANNELS];
  logic [CHANNELS-1:0] shadow_dir;
  logic [WIDTH-1:0]    active_duty [CHANNELS];
  logic [CHANNELS-1:0] active_dir;
  ch_state_t           state       [CHANNELS];
  logic [DC_W-1:0]     dead_cnt    [CHANNELS];

  // run_load: next active duty when a channel stays in RUN.
  // fresh_load: next active duty when a channel starts from zero (leaving
  // DEAD, or an immediate reversal with DEADTIME = 0).
  logic [WIDTH-1:0] run_load   [CHANNELS];
  logic [WIDTH-1:0] fresh_load [CHANNELS];

  // Move cur toward tgt by at most RAMP_INC, without overshoot.
  function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] gap;
    if (tgt >= cur) begin
      gap = {1'b0, tgt - cur};
      if (gap > RAMP_INC) ramp_toward = cur + RAMP_INC[WIDTH-1:0];
      else                ramp_toward = tgt;
    end else begin
      gap = {1'b0, cur - tgt};
      if (gap > RAMP_INC) ramp_toward = cur - RAMP_INC[WIDTH-1:0];
      else                ramp_toward = tgt;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Prescaler and period counter. The >= compares make a live decrease of
  // prescale or period take effect on the next clk instead of waiting for
  // the counters to roll over.
  // ---------------------------------------------------------------------
  assign tick = (pcnt >= prescale);
  assign wrap = tick && (cnt >= period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      if (tick) pcnt <= '0;
      else      pcnt <= pcnt + PRESC_W'(1);

      if (wrap)      cnt <= '0;
      else if (tick) cnt <= cnt + WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Shadow registers. A decode of wr_ch against every valid index silently
  // drops writes to channel numbers that do not exist.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_duty[i] <= '0;
      end
      shadow_dir <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_ch == CH_W'(i)) begin
          shadow_duty[i] <= wr_duty;
          shadow_dir[i]  <= wr_dir;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      run_load[i]   = shadow_duty[i];
      fresh_load[i] = shadow_duty[i];
`ifdef PWM_RAMP_EN
      run_load[i]   = ramp_toward(active_duty[i], shadow_duty[i]);
      fresh_load[i] = ramp_toward('0, shadow_duty[i]);
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel period-boundary FSM. It acts only on wrap, and it reads the
  // pre-edge shadow values. A write in the wrap cycle therefore waits for the
  // next wrap.
  //
  //   state   | meaning
  //   --------+------------------------------------------------------------
  //   ST_RUN  | spd follows cnt < active_duty; shadow loads on each wrap
  //   ST_DEAD | direction reversal pending; spd forced low, active_duty = 0,
  //           | dead_cnt counts the remaining whole periods
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]       <= ST_RUN;
        active_duty[i] <= '0;
        dead_cnt[i]    <= '0;
      end
      active_dir <= '0;
    end else if (wrap) begin
      for (int i = 0; i < CHANNELS; i++) begin
        case (state[i])
          ST_RUN: begin
            if (shadow_dir[i] == active_dir[i]) begin
              active_duty[i] <= run_load[i];
            end else if (DEADTIME > 0) begin
              // The dir output keeps the old direction during the dead time.
              state[i]       <= ST_DEAD;
              dead_cnt[i]    <= DEAD_INIT;
              active_duty[i] <= '0;
            end else begin
              active_duty[i] <= fresh_load[i];
              active_dir[i]  <= shadow_dir[i];
            end
          end
          ST_DEAD: begin
            if (dead_cnt[i] != '0) begin
              dead_cnt[i] <= dead_cnt[i] - DC_W'(1);
            end else begin
              state[i]       <= ST_RUN;
              active_duty[i] <= fresh_load[i];
              active_dir[i]  <= shadow_dir[i];
            end
          end
          default: begin
            state[i]       <= ST_RUN;
            active_duty[i] <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs, each one clk behind its cnt/state decision.
  // A duty of 0 never fires. A duty above period always fires, because cnt
  // never reaches it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd          <= '0;
      dir          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      dir          <= active_dir;
      for (int i = 0; i < CHANNELS; i++) begin
        spd[i] <= (state[i] == ST_RUN) && (cnt < active_duty[i]);
      end
    end
  end

endmodule
